// File: rtl/trisc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : trisc_pkg                                                       |
// | Purpose  : Shared definitions for the TRISC core: opcode field width,     |
// |            opcode values and the controller state type.                   |
// | Revision : 1.0  initial parametrised release                              |
// +----------------------------------------------------------------------------+
package trisc_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h1;
  localparam logic [OPC_W-1:0] OP_LDA = 4'h2;
  localparam logic [OPC_W-1:0] OP_STA = 4'h3;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h4;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h5;
  localparam logic [OPC_W-1:0] OP_AND = 4'h6;
  localparam logic [OPC_W-1:0] OP_OR  = 4'h7;
  localparam logic [OPC_W-1:0] OP_XOR = 4'h8;
  localparam logic [OPC_W-1:0] OP_NOT = 4'h9;
  localparam logic [OPC_W-1:0] OP_SHL = 4'hA;
  localparam logic [OPC_W-1:0] OP_SHR = 4'hB;
  localparam logic [OPC_W-1:0] OP_JMP = 4'hC;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'hD;
  localparam logic [OPC_W-1:0] OP_JC  = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/trisc_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : trisc_alu                                                       |
// | Purpose  : Combinational accumulator ALU for the TRISC core.              |
// | Ports    : opcode      - IR opcode field                                  |
// |            acc         - current accumulator                              |
// |            operand     - IR operand field K                               |
// |            carry_in    - current carry flag                               |
// |            result      - new accumulator value                            |
// |            carry_out   - new carry flag value                             |
// |            write_acc   - op writes acc (and therefore zero)               |
// |            write_carry - op writes carry                                  |
// | Revision : 1.0  initial parametrised release                              |
// +----------------------------------------------------------------------------+
module trisc_alu
  import trisc_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  logic              carry_in,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              write_acc,
  output logic              write_carry
);

  logic [DATA_W:0] w_sum;

  always_comb begin
    result      = acc;
    carry_out   = carry_in;
    write_acc   = 1'b0;
    write_carry = 1'b0;
    w_sum       = {1'b0, acc} + {1'b0, operand};
    case (opcode)
      OP_LDI: begin result = operand;       write_acc = 1'b1; end
      OP_ADD: begin
        result      = w_sum[DATA_W-1:0];
        carry_out   = w_sum[DATA_W];
        write_acc   = 1'b1;
        write_carry = 1'b1;
      end
      OP_SUB: begin
        result      = acc - operand;
        carry_out   = (acc < operand);   // borrow
        write_acc   = 1'b1;
        write_carry = 1'b1;
      end
      OP_AND: begin result = acc & operand; write_acc = 1'b1; end
      OP_OR:  begin result = acc | operand; write_acc = 1'b1; end
      OP_XOR: begin result = acc ^ operand; write_acc = 1'b1; end
      OP_NOT: begin result = ~acc;          write_acc = 1'b1; end
      OP_SHL: begin
        result      = {acc[DATA_W-2:0], 1'b0};
        carry_out   = acc[DATA_W-1];
        write_acc   = 1'b1;
        write_carry = 1'b1;
      end
      OP_SHR: begin
        result      = {1'b0, acc[DATA_W-1:1]};
        carry_out   = acc[0];
        write_acc   = 1'b1;
        write_carry = 1'b1;
      end
      default: ;  // NOP, LDA (written in WB), STA, jumps, HLT
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/trisc_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : trisc_core                                                      |
// | Purpose  : Parametrised TRISC accumulator machine: PC, IR, accumulator,   |
// |            flags, FSM controller and internal program/data RAM.           |
// | Ports    : clock, reset_n        - clock / async active-low reset         |
// |            run, step             - free-run level / single-step pulse     |
// |            prog_en, prog_we,                                              |
// |            prog_addr, prog_data  - program-load port                      |
// |            mem_q                 - registered RAM read data               |
// |            pc, acc, opcode       - architectural state                    |
// |            carry, zero           - flags                                  |
// |            halted, busy          - controller status                      |
// | Revision : 1.0  initial parametrised release                              |
// +----------------------------------------------------------------------------+
module trisc_core
  import trisc_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    run,
  input  logic                    step,
  input  logic                    prog_en,
  input  logic                    prog_we,
  input  logic [ADDR_W-1:0]       prog_addr,
  input  logic [OPC_W+DATA_W-1:0] prog_data,
  output logic [OPC_W+DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0]       pc,
  output logic [DATA_W-1:0]       acc,
  output logic [OPC_W-1:0]        opcode,
  output logic                    carry,
  output logic                    zero,
  output logic                    halted,
  output logic                    busy
);

  localparam int WORD_W = OPC_W + DATA_W;
  localparam int DEPTH  = 1 << ADDR_W;

  state_t              r_state, w_nextState;
  logic [ADDR_W-1:0]   r_pc;
  logic [WORD_W-1:0]   r_ir;
  logic [DATA_W-1:0]   r_acc;
  logic                r_carry, r_zero;
  logic [WORD_W-1:0]   r_memQ;
  logic [WORD_W-1:0]   r_mem [DEPTH];

  logic [OPC_W-1:0]    w_irOp;
  logic [DATA_W-1:0]   w_irK;
  logic [ADDR_W-1:0]   w_irAddr;
  logic [ADDR_W-1:0]   w_memAddr;
  logic [WORD_W-1:0]   w_memWdata;
  logic                w_memWe;
  logic                w_jump;
  logic [DATA_W-1:0]   w_aluResult;
  logic                w_aluCarry, w_aluWriteAcc, w_aluWriteCarry;

  assign w_irOp   = r_ir[WORD_W-1:DATA_W];
  assign w_irK    = r_ir[DATA_W-1:0];
  assign w_irAddr = w_irK[ADDR_W-1:0];

  trisc_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode      (w_irOp),
    .acc         (r_acc),
    .operand     (w_irK),
    .carry_in    (r_carry),
    .result      (w_aluResult),
    .carry_out   (w_aluCarry),
    .write_acc   (w_aluWriteAcc),
    .write_carry (w_aluWriteCarry)
  );

  assign w_jump = (w_irOp == OP_JMP) ||
                  ((w_irOp == OP_JZ) && r_zero) ||
                  ((w_irOp == OP_JC) && r_carry);

  // RAM port ownership: program port wins; EXEC addresses the operand (LDA/STA),
  // every other state addresses pc so the FETCH read lands in mem_q for DECODE.
  always_comb begin
    w_memAddr  = r_pc;
    w_memWe    = 1'b0;
    w_memWdata = {{OPC_W{1'b0}}, r_acc};
    if (prog_en) begin
      w_memAddr  = prog_addr;
      w_memWe    = prog_we;
      w_memWdata = prog_data;
    end else if (r_state == EXEC) begin
      w_memAddr = w_irAddr;
      w_memWe   = (w_irOp == OP_STA);
    end
  end

  // RAM array has no reset; contents survive reset_n.
  always_ff @(posedge clock) begin
    if (w_memWe) r_mem[w_memAddr] <= w_memWdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_memQ <= '0;
    else          r_memQ <= r_mem[w_memAddr];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (prog_en) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (run || step) w_nextState = FETCH;
        FETCH:   w_nextState = DECODE;
        DECODE:  w_nextState = EXEC;
        EXEC: begin
          if (w_irOp == OP_LDA)      w_nextState = WB;
          else if (w_irOp == OP_HLT) w_nextState = HALT;
          else                       w_nextState = run ? FETCH : IDLE;
        end
        WB:      w_nextState = run ? FETCH : IDLE;
        HALT:    w_nextState = HALT;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Architectural registers. prog_en aborts any in-flight update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= '0;
      r_ir    <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b1;
    end else if (prog_en) begin
      r_pc <= '0;
    end else begin
      case (r_state)
        DECODE: begin
          r_ir <= r_memQ;
          r_pc <= r_pc + ADDR_W'(1);
        end
        EXEC: begin
          if (w_aluWriteAcc) begin
            r_acc  <= w_aluResult;
            r_zero <= (w_aluResult == '0);
          end
          if (w_aluWriteCarry) r_carry <= w_aluCarry;
          if (w_jump)          r_pc    <= w_irAddr;
        end
        WB: begin
          r_acc  <= r_memQ[DATA_W-1:0];
          r_zero <= (r_memQ[DATA_W-1:0] == '0);
        end
        default: ;
      endcase
    end
  end

  assign mem_q  = r_memQ;
  assign pc     = r_pc;
  assign acc    = r_acc;
  assign opcode = w_irOp;
  assign carry  = r_carry;
  assign zero   = r_zero;
  assign halted = (r_state == HALT);
  assign busy   = (r_state == FETCH) || (r_state == DECODE) ||
                  (r_state == EXEC)  || (r_state == WB);

endmodule
`default_nettype wire

// File: tb/tb_trisc_core.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_trisc_core                                                   |
// | Purpose  : Self-checking bench for trisc_core: directed scenarios on a    |
// |            default instance and an 8/6 instance, plus random programs     |
// |            single-stepped against an instruction-level ISA model.        |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_trisc_core;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // Instance A: DATA_W=4, ADDR_W=4
  logic       aRun, aStep, aProgEn, aProgWe;
  logic [3:0] aProgAddr;
  logic [7:0] aProgData;
  logic [7:0] aMemQ;
  logic [3:0] aPc, aAcc, aOpcode;
  logic       aCarry, aZero, aHalted, aBusy;

  // Instance B: DATA_W=8, ADDR_W=6
  logic        bRun, bStep, bProgEn, bProgWe;
  logic [5:0]  bProgAddr;
  logic [11:0] bProgData;
  logic [11:0] bMemQ;
  logic [5:0]  bPc;
  logic [7:0]  bAcc;
  logic [3:0]  bOpcode;
  logic        bCarry, bZero, bHalted, bBusy;

  trisc_core #(.DATA_W(4), .ADDR_W(4)) dutA (
    .clock(clock), .reset_n(reset_n), .run(aRun), .step(aStep),
    .prog_en(aProgEn), .prog_we(aProgWe), .prog_addr(aProgAddr), .prog_data(aProgData),
    .mem_q(aMemQ), .pc(aPc), .acc(aAcc), .opcode(aOpcode),
    .carry(aCarry), .zero(aZero), .halted(aHalted), .busy(aBusy)
  );

  trisc_core #(.DATA_W(8), .ADDR_W(6)) dutB (
    .clock(clock), .reset_n(reset_n), .run(bRun), .step(bStep),
    .prog_en(bProgEn), .prog_we(bProgWe), .prog_addr(bProgAddr), .prog_data(bProgData),
    .mem_q(bMemQ), .pc(bPc), .acc(bAcc), .opcode(bOpcode),
    .carry(bCarry), .zero(bZero), .halted(bHalted), .busy(bBusy)
  );

  int passCnt  = 0;
  int checkCnt = 0;

  // ISA-level model of instance A
  int mMem [16];
  int mPc, mAcc, mCarry, mZero, mHalted;

  task automatic loadA(input int addr, input int data);
    @(negedge clock);
    aProgEn = 1'b1; aProgWe = 1'b1;
    aProgAddr = 4'(addr); aProgData = 8'(data);
    mMem[addr] = data;
  endtask

  task automatic endLoadA();
    @(negedge clock);
    aProgEn = 1'b0; aProgWe = 1'b0;
    mPc = 0; mHalted = 0;
  endtask

  task automatic loadB(input int addr, input int data);
    @(negedge clock);
    bProgEn = 1'b1; bProgWe = 1'b1;
    bProgAddr = 6'(addr); bProgData = 12'(data);
  endtask

  task automatic endLoadB();
    @(negedge clock);
    bProgEn = 1'b0; bProgWe = 1'b0;
  endtask

  // Raise run, then count edges after the edge that first sees run until halted.
  task automatic runUntilHaltA(output int n);
    @(negedge clock); aRun = 1'b1;
    @(posedge clock); #1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      n++;
      if (aHalted) break;
    end
    aRun = 1'b0;
  endtask

  task automatic stepA();
    @(negedge clock); aStep = 1'b1;
    @(negedge clock); aStep = 1'b0;
    for (int i = 0; i < 12 && aBusy; i++) @(negedge clock);
  endtask

  task automatic stepB();
    @(negedge clock); bStep = 1'b1;
    @(negedge clock); bStep = 1'b0;
    for (int i = 0; i < 12 && bBusy; i++) @(negedge clock);
  endtask

  task automatic modelStep();
    int w, op, k, s;
    w  = mMem[mPc];
    op = w / 16;
    k  = w % 16;
    mPc = (mPc + 1) % 16;
    case (op)
      1:  mAcc = k;
      2:  mAcc = mMem[k] % 16;
      3:  mMem[k] = mAcc;
      4:  begin s = mAcc + k; mCarry = (s > 15) ? 1 : 0; mAcc = s % 16; end
      5:  begin mCarry = (mAcc < k) ? 1 : 0; mAcc = (mAcc - k + 16) % 16; end
      6:  mAcc = mAcc & k;
      7:  mAcc = mAcc | k;
      8:  mAcc = mAcc ^ k;
      9:  mAcc = 15 - mAcc;
      10: begin mCarry = (mAcc >= 8) ? 1 : 0; mAcc = (mAcc * 2) % 16; end
      11: begin mCarry = mAcc % 2; mAcc = mAcc / 2; end
      12: mPc = k;
      13: if (mZero != 0) mPc = k;
      14: if (mCarry != 0) mPc = k;
      15: mHalted = 1;
      default: ;
    endcase
    if (op == 1 || op == 2 || (op >= 4 && op <= 11)) mZero = (mAcc == 0) ? 1 : 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checkCnt++;
    if ({aPc, aAcc, aOpcode, aCarry, aZero, aHalted, aBusy, aMemQ} !== {4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_state: got pc=%h acc=%h op=%h c=%b z=%b h=%b b=%b q=%h, want all zero with zero=1",
               aPc, aAcc, aOpcode, aCarry, aZero, aHalted, aBusy, aMemQ);
    else passCnt++;
    @(negedge clock); reset_n = 1'b1;
    mAcc = 0; mCarry = 0; mZero = 1; mPc = 0; mHalted = 0;
  endtask

  task automatic test_basic();
    int n;
    loadA(0, 'h15); loadA(1, 'h43); loadA(2, 'hF0); endLoadA();
    runUntilHaltA(n);
    checkCnt++; if (n !== 9)  $display("FAIL basic_halt_latency: got %0d want 9", n); else passCnt++;
    checkCnt++; if (aAcc !== 4'h8) $display("FAIL basic_acc: got %h want 8", aAcc); else passCnt++;
    checkCnt++; if ({aCarry, aZero} !== 2'b00) $display("FAIL basic_flags: got c=%b z=%b want 0 0", aCarry, aZero); else passCnt++;
    checkCnt++; if ({aHalted, aPc} !== {1'b1, 4'h3}) $display("FAIL basic_halt_pc: got h=%b pc=%h want 1 3", aHalted, aPc); else passCnt++;
  endtask

  task automatic test_overflow();
    bit seen;
    loadA(0, 'h1F); loadA(1, 'h41); loadA(2, 'hE5);
    loadA(3, 'hF0); loadA(4, 'h00); loadA(5, 'hF0); endLoadA();
    @(negedge clock); aRun = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (aOpcode == 4'hE) begin seen = 1'b1; break; end
    end
    checkCnt++;
    if (!seen || {aAcc, aZero, aCarry} !== {4'h0, 1'b1, 1'b1})
      $display("FAIL overflow_add: got seen=%b acc=%h z=%b c=%b want acc=0 z=1 c=1", seen, aAcc, aZero, aCarry);
    else passCnt++;
    for (int i = 0; i < 30 && !aHalted; i++) @(negedge clock);
    aRun = 1'b0;
    checkCnt++;
    if ({aHalted, aPc} !== {1'b1, 4'h6}) $display("FAIL overflow_jc: got h=%b pc=%h want 1 6", aHalted, aPc);
    else passCnt++;
  endtask

  task automatic test_memory();
    int n;
    loadA(0, 'h1A); loadA(1, 'h3E); loadA(2, 'h10); loadA(3, 'h2E); loadA(4, 'hF0); endLoadA();
    runUntilHaltA(n);
    checkCnt++; if (n !== 16) $display("FAIL memory_cycles: got %0d want 16 (LDA=4)", n); else passCnt++;
    checkCnt++; if (aAcc !== 4'hA) $display("FAIL memory_lda_acc: got %h want a", aAcc); else passCnt++;
    @(negedge clock); aProgEn = 1'b1; aProgWe = 1'b0; aProgAddr = 4'hE;
    @(posedge clock); #1;
    checkCnt++; if (aMemQ !== 8'h0A) $display("FAIL memory_sta_word: got %h want 0a", aMemQ); else passCnt++;
    @(negedge clock); aProgEn = 1'b0;
  endtask

  task automatic test_wrap_step();
    int busyCnt;
    loadA(0, 'hCF); loadA(15, 'h00); endLoadA();
    @(negedge clock); aStep = 1'b1;
    @(negedge clock); aStep = 1'b0;
    busyCnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (aBusy) busyCnt++;
      aStep = (i == 2);   // stray step while EXEC is in progress
      @(negedge clock);
    end
    aStep = 1'b0;
    checkCnt++; if (busyCnt !== 3) $display("FAIL step_busy_cycles: got %0d want 3", busyCnt); else passCnt++;
    checkCnt++; if ({aBusy, aPc} !== {1'b0, 4'hF}) $display("FAIL step_jmp_pc_ignored: got busy=%b pc=%h want 0 f", aBusy, aPc); else passCnt++;
    stepA();
    checkCnt++; if (aPc !== 4'h0) $display("FAIL step_pc_wrap: got %h want 0", aPc); else passCnt++;
  endtask

  task automatic test_abort();
    bit seen;
    loadA(0, 'h17); loadA(1, 'h41); loadA(2, 'hC1); endLoadA();
    @(negedge clock); aRun = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (aOpcode == 4'h4) begin seen = 1'b1; break; end
    end
    aProgEn = 1'b1; aProgWe = 1'b0; aProgAddr = 4'h1;
    @(posedge clock); #1;
    checkCnt++;
    if (!seen || aAcc !== 4'h7) $display("FAIL abort_acc: got seen=%b acc=%h want 7", seen, aAcc); else passCnt++;
    checkCnt++;
    if ({aPc, aBusy, aHalted} !== {4'h0, 1'b0, 1'b0}) $display("FAIL abort_idle: got pc=%h b=%b h=%b want 0 0 0", aPc, aBusy, aHalted); else passCnt++;
    checkCnt++; if (aMemQ !== 8'h41) $display("FAIL abort_prog_read: got %h want 41", aMemQ); else passCnt++;
    @(negedge clock); aRun = 1'b0; aProgEn = 1'b0;
  endtask

  task automatic test_random();
    int op, a;
    test_reset();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 16; i++) begin
        op = $urandom_range(0, 15);
        if (op == 15 && $urandom_range(0, 3) != 0) op = 0;
        loadA(i, op * 16 + $urandom_range(0, 15));
      end
      endLoadA();
      for (int s = 0; s < 20 && mHalted == 0; s++) begin
        stepA();
        modelStep();
        checkCnt++;
        if ({aPc, aAcc, aCarry, aZero, aHalted, aBusy} !==
            {4'(mPc), 4'(mAcc), 1'(mCarry), 1'(mZero), 1'(mHalted), 1'b0})
          $display("FAIL random_step p%0d s%0d: got pc=%h acc=%h c=%b z=%b h=%b b=%b want pc=%h acc=%h c=%0d z=%0d h=%0d b=0",
                   p, s, aPc, aAcc, aCarry, aZero, aHalted, aBusy, mPc, mAcc, mCarry, mZero, mHalted);
        else passCnt++;
      end
      for (int i = 0; i < 4; i++) begin
        a = $urandom_range(0, 15);
        @(negedge clock); aProgEn = 1'b1; aProgWe = 1'b0; aProgAddr = 4'(a);
        @(posedge clock); #1;
        checkCnt++;
        if (aMemQ !== 8'(mMem[a])) $display("FAIL random_ram[%0d]: got %h want %h", a, aMemQ, 8'(mMem[a]));
        else passCnt++;
      end
      @(negedge clock); aProgEn = 1'b0;
      mPc = 0; mHalted = 0;
    end
  endtask

  task automatic test_params();
    loadB(0, 'h1FF); loadB(1, 'h501); loadB(2, 'h5FF); loadB(3, 'hF00); endLoadB();
    stepB();
    checkCnt++; if (bAcc !== 8'hFF) $display("FAIL param_ldi: got %h want ff", bAcc); else passCnt++;
    stepB();
    checkCnt++; if ({bAcc, bCarry} !== {8'hFE, 1'b0}) $display("FAIL param_sub1: got acc=%h c=%b want fe 0", bAcc, bCarry); else passCnt++;
    stepB();
    checkCnt++; if ({bAcc, bCarry} !== {8'hFF, 1'b1}) $display("FAIL param_sub_borrow: got acc=%h c=%b want ff 1", bAcc, bCarry); else passCnt++;
    // Step the HLT and drop reset while it sits in EXEC.
    @(negedge clock); bStep = 1'b1;
    @(negedge clock); bStep = 1'b0;   // FETCH
    @(negedge clock);                 // DECODE
    @(negedge clock);                 // EXEC
    checkCnt++; if ({bBusy, bOpcode} !== {1'b1, 4'hF}) $display("FAIL param_in_exec: got b=%b op=%h want 1 f", bBusy, bOpcode); else passCnt++;
    #2 reset_n = 1'b0;
    #1;
    checkCnt++;
    if ({bPc, bAcc, bOpcode, bCarry, bZero, bHalted, bBusy, bMemQ} !== {6'h0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000})
      $display("FAIL param_async_reset: got pc=%h acc=%h op=%h c=%b z=%b h=%b b=%b q=%h, want zeros with zero=1",
               bPc, bAcc, bOpcode, bCarry, bZero, bHalted, bBusy, bMemQ);
    else passCnt++;
    @(negedge clock); reset_n = 1'b1;
  endtask

  initial begin
    aRun = 1'b0; aStep = 1'b0; aProgEn = 1'b0; aProgWe = 1'b0; aProgAddr = '0; aProgData = '0;
    bRun = 1'b0; bStep = 1'b0; bProgEn = 1'b0; bProgWe = 1'b0; bProgAddr = '0; bProgData = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_memory();
    test_wrap_step();
    test_abort();
    test_random();
    test_params();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trisc_core.md
Name: trisc_core

Overview:
- Parametrised successor to the fixed 4-bit TRISC accumulator machine.
- Holds the program counter, instruction register, accumulator, flags, a single FSM controller and an internal synchronous program/data RAM.
- Memory word is {opcode[3:0], operand[DATA_W-1:0]}.
- Adds the following, none of which the fixed machine has:
  - width/depth parameters
  - a full 16-op ISA with conditional jumps
  - single-step mode
  - halt state
  - program-load port

Parameters:
- DATA_W, 4: accumulator/operand width; legal range 4..16.
- ADDR_W, 4: RAM address width; depth = 2**ADDR_W; must satisfy ADDR_W <= DATA_W.

Ports:
- clock  in  1  system clock; rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level; high = free-running execution.
- step  in  1  one-cycle pulse; executes one instruction while idle and run=0.
- prog_en  in  1  program mode; core held, RAM owned by the prog_* port.
- prog_we  in  1  RAM write strobe in program mode.
- prog_addr  in  ADDR_W  program-mode RAM address.
- prog_data  in  4+DATA_W  program-mode write word.
- mem_q  out  4+DATA_W  RAM read data; the prog_addr word in program mode.
- pc  out  ADDR_W  program counter.
- acc  out  DATA_W  accumulator.
- opcode  out  4  IR opcode field.
- carry  out  1  carry/borrow flag.
- zero  out  1  acc==0 flag.
- halted  out  1  high in HALT state.
- busy  out  1  high in FETCH/DECODE/EXEC/WB.

Behaviour:
- Reset (async, reset_n=0): pc=0, acc=0, IR=0, carry=0, zero=1, state=IDLE, halted=0, busy=0, mem_q=0. RAM contents are not cleared.
- RAM: synchronous write; registered read with 1-cycle latency.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE:
  - run=1 or a step pulse -> FETCH.
  - A step pulse arriving while run=1 is ignored.
- FETCH: RAM address = pc -> DECODE.
- DECODE: IR <= mem_q; pc <= pc+1 (mod 2**ADDR_W, so all-ones wraps to 0) -> EXEC.
- EXEC executes the op per the map below, then:
  - LDA -> WB.
  - HLT -> HALT.
  - Any other op: -> FETCH if run=1, else -> IDLE.
- WB: acc <= mem_q operand field; zero updated -> FETCH if run=1, else -> IDLE.
- Instruction length: 3 cycles; LDA takes 4. A step pulse therefore executes exactly one instruction.
- Opcode map (operand K; address A = K[ADDR_W-1:0]):
  - 0 NOP
  - 1 LDI: acc=K
  - 2 LDA: acc=RAM[A]
  - 3 STA: RAM[A]={4'h0,acc}
  - 4 ADD: {carry,acc}=acc+K
  - 5 SUB: acc=acc-K; carry=1 when acc<K (borrow)
  - 6 AND: acc&=K
  - 7 OR: acc|=K
  - 8 XOR: acc^=K
  - 9 NOT: acc=~acc
  - A SHL: carry=acc MSB; acc<<1
  - B SHR: carry=acc LSB; acc>>1
  - C JMP: pc=A
  - D JZ: pc=A if zero
  - E JC: pc=A if carry
  - F HLT
- Flags:
  - zero is updated by every op that writes acc.
  - carry is updated only by ADD, SUB, SHL, SHR.
  - Jumps change neither flag.
- Arithmetic is unsigned and modulo 2**DATA_W.
- run dropped mid-instruction: the current instruction completes, then -> IDLE.
- HALT: left only by reset or prog_en. run and step are ignored.
- prog_en=1, from any state, takes effect at the next edge:
  - The in-flight instruction is aborted: no acc/flag/RAM write, no pc change.
  - state -> IDLE; pc cleared to 0 on every cycle prog_en is high; acc and flags retained; busy=0, halted=0.
  - RAM address = prog_addr; RAM is written when prog_we=1.
  - mem_q gives RAM[prog_addr] one cycle after the address is presented.
- prog_en=0 forces prog_we to be ignored.

Decomposition:
- Package trisc_pkg holds:
  - opcode localparams OP_NOP..OP_HLT
  - state enum (IDLE, FETCH, DECODE, EXEC, WB, HALT)
  - OPC_W=4
- Sub-module trisc_alu is combinational and parametrised on DATA_W:
  - inputs: opcode, acc, operand, carry_in
  - outputs: result, carry_out, write_acc, write_carry
- RAM array, FSM and registers stay in trisc_core.

Test Plan:
- Defaults. Program via prog port: 0:LDI 5, 1:ADD 3, 2:HLT. Then prog_en=0, run=1. Required:
  - acc=8, carry=0, zero=0.
  - halted=1 exactly 9 cycles after run rises; pc=3.
- Overflow. Program: LDI F, ADD 1, JC 5, HLT @3, NOP @4, HLT @5. Run. Required:
  - After ADD: acc=0, zero=1, carry=1.
  - Jump taken; halted with pc=6.
- Memory. Program: LDI A, STA E, LDI 0, LDA E, HLT. Run. Required:
  - RAM[E]=0x0A.
  - acc=A.
  - LDA takes 4 cycles.
- Wrap and step. Program: JMP F at 0; NOP at F; run=0; issue step pulses. Required:
  - After step 1: pc=F; busy high exactly 3 cycles.
  - After step 2: pc=0 (wrap).
  - A step asserted while busy is ignored.
- Abort. Run a LDI 7 / ADD 1 / JMP 1 loop. Assert prog_en during EXEC of ADD. Required:
  - No acc change from the aborted ADD.
  - state=IDLE, pc=0.
  - Reading prog_addr=1 returns 0x41 on mem_q one cycle later.
- Parameters and reset. Instance with DATA_W=8, ADDR_W=6:
  - LDI 0xFF, SUB 0x01 -> acc=0xFE, carry=0.
  - SUB 0xFF -> acc=0xFF, carry=1.
  - Assert reset_n=0 mid-EXEC -> all outputs at reset values immediately, with no clock edge.
